// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: instruction format codes, major-opcode constants
// (bits [6:2]) and the per-entry decoded field bundle.
package decode_stage_pkg;

    // Format codes produced by the instr_type classifier
    localparam logic [2:0] INVALID = 3'd0;
    localparam logic [2:0] R_TYPE  = 3'd1;
    localparam logic [2:0] I_TYPE  = 3'd2;
    localparam logic [2:0] S_TYPE  = 3'd3;
    localparam logic [2:0] B_TYPE  = 3'd4;
    localparam logic [2:0] U_TYPE  = 3'd5;
    localparam logic [2:0] J_TYPE  = 3'd6;
    localparam logic [2:0] R4_TYPE = 3'd7;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_LOAD_FP  = 5'b00001;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_STORE_FP = 5'b01001;
    localparam logic [4:0] OPC_AMO      = 5'b01011;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_OP_32    = 5'b01110;
    localparam logic [4:0] OPC_MADD     = 5'b10000;
    localparam logic [4:0] OPC_MSUB     = 5'b10001;
    localparam logic [4:0] OPC_NMSUB    = 5'b10010;
    localparam logic [4:0] OPC_NMADD    = 5'b10011;
    localparam logic [4:0] OPC_OP_FP    = 5'b10100;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    // XLEN-independent part of a decoded entry; pc/imm are carried separately
    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  itype;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: assembles the 32-bit format immediate and sign-extends
// it from instr[31] to XLEN. R, R4 and INVALID formats yield zero.
module imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      itype,
    output logic [XLEN-1:0] imm
);

    logic [31:0] w_imm32;
    logic        w_unused;

    // opcode bits never contribute to the immediate
    assign w_unused = ^instr[6:0];

    // Per-format bit gathering into a sign-extended 32-bit value
    always_comb begin
        w_imm32 = '0;
        case (itype)
            I_TYPE: w_imm32 = {{20{instr[31]}}, instr[31:20]};
            S_TYPE: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            B_TYPE: w_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
            U_TYPE: w_imm32 = {instr[31:12], 12'b0};
            J_TYPE: w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Widen to XLEN, replicating bit 31 above the 32-bit result
    always_comb begin
        imm = '0;
        for (int i = 0; i < XLEN; i++)
            imm[i] = (i < 32) ? w_imm32[i] : w_imm32[31];
    end

endmodule

// File: rtl/instr_type.sv
// Major-opcode classifier: maps instr[6:2] to a format code, INVALID otherwise.
module instr_type
    import decode_stage_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [2:0] itype
);

    // Pure lookup on the major opcode
    always_comb begin
        itype = INVALID;
        case (opcode)
            OPC_OP, OPC_OP_32, OPC_OP_FP, OPC_AMO:             itype = R_TYPE;
            OPC_LOAD, OPC_LOAD_FP, OPC_MISC_MEM, OPC_OP_IMM,
            OPC_OP_IMM32, OPC_JALR, OPC_SYSTEM:                itype = I_TYPE;
            OPC_STORE, OPC_STORE_FP:                           itype = S_TYPE;
            OPC_BRANCH:                                        itype = B_TYPE;
            OPC_LUI, OPC_AUIPC:                                itype = U_TYPE;
            OPC_JAL:                                           itype = J_TYPE;
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD:          itype = R4_TYPE;
            default:                                           itype = INVALID;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage behind a valid/ready handshake with a two-entry
// (main + skid) buffer so in_ready comes straight from a flop.
// Optional statistics counters are enabled by defining DECODE_STATS_EN.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_type,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_illegal
`ifdef DECODE_STATS_EN
    ,
    output logic [31:0]     stat_decoded,
    output logic [31:0]     stat_stall,
    output logic [15:0]     stat_illegal
`endif
);

    logic [2:0]      w_itype;
    logic [XLEN-1:0] w_imm_raw;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    dec_t            w_new;
    logic            w_accept;
    logic            w_consume;

    dec_t            r_main;
    logic [XLEN-1:0] r_main_pc;
    logic [XLEN-1:0] r_main_imm;
    logic            r_main_valid;
    dec_t            r_skid;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_skid_imm;
    logic            r_skid_valid;
    logic            r_in_ready;

    instr_type u_instr_type (
        .opcode (in_instr[6:2]),
        .itype  (w_itype)
    );

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr  (in_instr),
        .itype  (w_itype),
        .imm    (w_imm_raw)
    );

    // Input-side decode; illegal words carry a zero immediate
    always_comb begin
        w_illegal     = (in_instr[1:0] != 2'b11) || (w_itype == INVALID);
        w_imm         = w_illegal ? '0 : w_imm_raw;
        w_new.instr   = in_instr;
        w_new.itype   = w_itype;
        w_new.rd      = in_instr[11:7];
        w_new.rs1     = in_instr[19:15];
        w_new.rs2     = in_instr[24:20];
        w_new.illegal = w_illegal;
    end

    // Anything arriving alongside flush is dropped, never stored
    assign w_accept  = in_valid && r_in_ready && !flush;
    assign w_consume = r_main_valid && out_ready;

    // Main/skid buffer control; in_ready is simply "skid will be empty"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_main_pc    <= '0;
            r_main_imm   <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_pc    <= '0;
            r_skid_imm   <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_consume || !r_main_valid) begin
            // Main is free this edge: oldest entry (skid) first, else new input
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_pc    <= r_skid_pc;
                r_main_imm   <= r_skid_imm;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_accept) begin
                r_main       <= w_new;
                r_main_pc    <= in_pc;
                r_main_imm   <= w_imm;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Main is stalled: park the accepted entry and close the input
            r_skid       <= w_new;
            r_skid_pc    <= in_pc;
            r_skid_imm   <= w_imm;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_main_valid;
    assign out_instr   = r_main.instr;
    assign out_pc      = r_main_pc;
    assign out_type    = r_main.itype;
    assign out_imm     = r_main_imm;
    assign out_rd      = r_main.rd;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_illegal = r_main.illegal;

`ifdef DECODE_STATS_EN
    logic [31:0] r_stat_decoded;
    logic [31:0] r_stat_stall;
    logic [15:0] r_stat_illegal;

    // Free-running wrap-around counters; only reset clears them, not flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_decoded <= '0;
            r_stat_stall   <= '0;
            r_stat_illegal <= '0;
        end else begin
            if (w_consume)
                r_stat_decoded <= r_stat_decoded + 32'd1;
            if (in_valid && !r_in_ready)
                r_stat_stall <= r_stat_stall + 32'd1;
            if (w_consume && r_main.illegal)
                r_stat_illegal <= r_stat_illegal + 16'd1;
        end
    end

    assign stat_decoded = r_stat_decoded;
    assign stat_stall   = r_stat_stall;
    assign stat_illegal = r_stat_illegal;
`endif

endmodule
